// File: rtl/bit_serializer.sv
// Parallel-to-serial stage: one WIDTH-bit word per valid/ready handshake, one bit per clock.
// Optional trailing even-parity bit when SERIALIZER_PARITY_EN is defined.
module bit_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             valid_in,
    output logic             ready_out,
    output logic             sout,
    output logic             bit_valid,
    output logic             busy,
    output logic             done
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_PAR   = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

`ifdef SERIALIZER_PARITY_EN
    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        SHIFT = ST_SHIFT,
        PAR   = ST_PAR,
        DONE  = ST_DONE
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        SHIFT = ST_SHIFT,
        DONE  = ST_DONE
    } state_t;
`endif

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_shreg;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] w_shifted;
    logic             w_out_bit;
    logic             w_accept;
    logic             w_last;

    assign w_accept = (r_state == IDLE) && valid_in;
    assign w_last   = (r_state == SHIFT) && (r_cnt == LAST_CNT);

    // Zero fill leaves the shift register empty outside SHIFT, so sout needs no state gating.
    generate
        if (MSB_FIRST) begin : g_msb
            assign w_shifted = {r_shreg[WIDTH-2:0], 1'b0};
            assign w_out_bit = r_shreg[WIDTH-1];
        end else begin : g_lsb
            assign w_shifted = {1'b0, r_shreg[WIDTH-1:1]};
            assign w_out_bit = r_shreg[0];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_shreg <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_shreg <= data_in;
                r_cnt   <= '0;
            end else if (r_state == SHIFT) begin
                r_shreg <= w_shifted;
                if (r_cnt != LAST_CNT) begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

`ifdef SERIALIZER_PARITY_EN
    logic r_parity;
    logic r_par_bit;

    // r_par_bit is nonzero only while in PAR, holding the parity of the accepted word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_parity  <= 1'b0;
            r_par_bit <= 1'b0;
        end else begin
            if (w_accept) begin
                r_parity <= ^data_in;
            end
            r_par_bit <= w_last ? r_parity : 1'b0;
        end
    end

    assign sout      = w_out_bit | r_par_bit;
    assign bit_valid = (r_state == SHIFT) || (r_state == PAR);
`else
    assign sout      = w_out_bit;
    assign bit_valid = (r_state == SHIFT);
`endif

    always_comb begin
        w_state_next = IDLE;
        case (r_state)
            IDLE:  w_state_next = valid_in ? SHIFT : IDLE;
`ifdef SERIALIZER_PARITY_EN
            SHIFT: w_state_next = w_last ? PAR : SHIFT;
            PAR:   w_state_next = DONE;
`else
            SHIFT: w_state_next = w_last ? DONE : SHIFT;
`endif
            DONE:  w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    assign ready_out = (r_state == IDLE);
    assign busy      = (r_state != IDLE);
    assign done      = (r_state == DONE);

endmodule

// File: tb/tb_bit_serializer.sv
// Directed bench for bit_serializer: an MSB-first and an LSB-first instance share clock and reset.
module tb_bit_serializer;
`ifdef SERIALIZER_PARITY_EN
    localparam int PAR_CYC = 1;
`else
    localparam int PAR_CYC = 0;
`endif

    logic       clk;
    logic       rst;
    logic [7:0] d_m, d_l;
    logic       v_m, v_l;
    logic       rdy_m, sout_m, bv_m, busy_m, done_m;
    logic       rdy_l, sout_l, bv_l, busy_l, done_l;
    logic       sel;
    int         checks;
    int         failures;

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rst(rst), .data_in(d_m), .valid_in(v_m), .ready_out(rdy_m),
        .sout(sout_m), .bit_valid(bv_m), .busy(busy_m), .done(done_m)
    );

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst(rst), .data_in(d_l), .valid_in(v_l), .ready_out(rdy_l),
        .sout(sout_l), .bit_valid(bv_l), .busy(busy_l), .done(done_l)
    );

    wire w_rdy  = sel ? rdy_l  : rdy_m;
    wire w_sout = sel ? sout_l : sout_m;
    wire w_bv   = sel ? bv_l   : bv_m;
    wire w_busy = sel ? busy_l : busy_m;
    wire w_done = sel ? done_l : done_m;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] data, input logic valid);
        if (sel) begin
            d_l = data; v_l = valid;
        end else begin
            d_m = data; v_m = valid;
        end
    endtask

    // seq lists the expected bits in transmit order, first bit in seq[7].
    task automatic run_word(input bit lsb, input logic [7:0] data, input logic [7:0] seq,
                            input bit par_exp, input string tag);
        sel = lsb;
        #0;
        drive(data, 1'b1);
        check({tag, "_rdy0"}, w_rdy, 1);
        tick();
        drive(~data, 1'b0);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("%s_bit%0d", tag, k), w_sout, seq[7-k]);
            check($sformatf("%s_bv%0d", tag, k), w_bv, 1);
            check($sformatf("%s_rdy%0d", tag, k), w_rdy, 0);
            tick();
        end
        if (PAR_CYC != 0) begin
            check({tag, "_par"}, w_sout, par_exp);
            check({tag, "_par_bv"}, w_bv, 1);
            check({tag, "_par_done"}, w_done, 0);
            tick();
        end
        check({tag, "_done"}, w_done, 1);
        check({tag, "_done_bv"}, w_bv, 0);
        check({tag, "_done_sout"}, w_sout, 0);
        check({tag, "_done_rdy"}, w_rdy, 0);
        tick();
        check({tag, "_idle_rdy"}, w_rdy, 1);
        check({tag, "_idle_done"}, w_done, 0);
        check({tag, "_idle_busy"}, w_busy, 0);
        $display("word %s data=%02h sent", tag, data);
    endtask

    initial begin
        logic [7:0] seq;
        checks = 0;
        failures = 0;
        sel = 1'b0;
        rst = 1'b1;
        d_m = 8'hFF; v_m = 1'b1;
        d_l = 8'hFF; v_l = 1'b1;

        // Reset held with valid_in high: no accept may happen.
        for (int c = 0; c < 3; c++) begin
            tick();
            check("rst_rdy", rdy_m, 1);
            check("rst_sout", sout_m, 0);
            check("rst_bv", bv_m, 0);
            check("rst_done", done_m, 0);
            check("rst_busy", busy_m, 0);
            check("rst_busy_l", busy_l, 0);
        end
        rst = 1'b0;
        v_m = 1'b0; v_l = 1'b0;
        tick();
        check("post_rst_busy", busy_m, 0);
        check("post_rst_rdy", rdy_m, 1);
        $display("reset sequence done");

        run_word(1'b0, 8'hA5, 8'b10100101, 1'b0, "msb_a5");
        run_word(1'b1, 8'h01, 8'b10000000, 1'b1, "lsb_01");
        run_word(1'b1, 8'hB2, 8'b01001101, 1'b0, "lsb_b2");

        // Back-to-back with valid_in held high on the MSB-first instance.
        sel = 1'b0;
        d_m = 8'hFF; v_m = 1'b1;
        tick();
        d_m = 8'h00;
        for (int k = 0; k < 8; k++) begin
            check($sformatf("b2b_w1_bit%0d", k), sout_m, 1);
            check($sformatf("b2b_w1_bv%0d", k), bv_m, 1);
            tick();
        end
        if (PAR_CYC != 0) begin
            check("b2b_w1_par", sout_m, 0);
            tick();
        end
        check("b2b_w1_done", done_m, 1);
        check("b2b_w1_done_rdy", rdy_m, 0);
        tick();
        check("b2b_accept_rdy", rdy_m, 1);
        tick();
        v_m = 1'b0; d_m = 8'hFF;
        for (int k = 0; k < 8; k++) begin
            check($sformatf("b2b_w2_bit%0d", k), sout_m, 0);
            check($sformatf("b2b_w2_bv%0d", k), bv_m, 1);
            tick();
        end
        if (PAR_CYC != 0) begin
            check("b2b_w2_par", sout_m, 0);
            tick();
        end
        check("b2b_w2_done", done_m, 1);
        tick();
        check("b2b_idle_rdy", rdy_m, 1);
        check("b2b_idle_busy", busy_m, 0);
        $display("back-to-back FF/00 sent");

        // Mid-word asynchronous reset during cycle 4 of word C3.
        d_m = 8'hC3; v_m = 1'b1;
        tick();
        v_m = 1'b0;
        seq = 8'b11000011;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("mid_bit%0d", k), sout_m, seq[7-k]);
            tick();
        end
        check("mid_busy_before", busy_m, 1);
        check("mid_bv_before", bv_m, 1);
        #2;
        rst = 1'b1;
        #1;
        check("mid_busy_async", busy_m, 0);
        check("mid_bv_async", bv_m, 0);
        check("mid_sout_async", sout_m, 0);
        check("mid_rdy_async", rdy_m, 1);
        tick();
        rst = 1'b0;
        for (int c = 0; c < 12; c++) begin
            check($sformatf("mid_nodone%0d", c), done_m, 0);
            check($sformatf("mid_nobv%0d", c), bv_m, 0);
            tick();
        end
        $display("mid-word reset aborted C3");
        run_word(1'b0, 8'h3C, 8'b00111100, 1'b0, "msb_3c");

        run_word(1'b0, 8'h07, 8'b00000111, 1'b1, "par_07");
        run_word(1'b0, 8'h03, 8'b00000011, 1'b0, "par_03");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
